// File: rtl/gray_bcid_tx.sv
// Free-running BCID counter with a registered Gray copy and an MSB-first serializer of one captured Gray word.
// Gray lags the counter by one cycle. A send while busy is dropped and flagged on Out_Overrun.
module gray_bcid_tx #(
  parameter int WIDTH      = 12,
  parameter int BIT_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Run,
  input  logic             In_Tick,
  input  logic             In_Clear,
  input  logic             In_Send,
  output logic [WIDTH-1:0] Out_Bin,
  output logic [WIDTH-1:0] Out_Gray,
  output logic             Out_Wrap,
  output logic             Out_Sdata,
  output logic             Out_Sbit,
  output logic             Out_Busy,
  output logic             Out_Done,
  output logic             Out_Overrun
);

  localparam int BW = $clog2(WIDTH);
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(BIT_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Out_Bin  <= '0;
      Out_Gray <= '0;
      Out_Wrap <= 1'b0;
    end else begin
      Out_Gray <= Out_Bin ^ (Out_Bin >> 1);
      Out_Wrap <= 1'b0;
      if (In_Clear) begin
        Out_Bin <= '0;
      end else if (In_Run && In_Tick) begin
        Out_Bin  <= Out_Bin + WIDTH'(1);
        Out_Wrap <= &Out_Bin;
      end
    end
  end

  // sreg is zeroed whenever the serializer is idle, so its MSB doubles as Out_Sdata.
  assign Out_Sdata = sreg[WIDTH-1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      hold_cnt    <= '0;
      Out_Sbit    <= 1'b0;
      Out_Busy    <= 1'b0;
      Out_Done    <= 1'b0;
      Out_Overrun <= 1'b0;
    end else begin
      Out_Sbit    <= 1'b0;
      Out_Done    <= 1'b0;
      Out_Overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (In_Send) begin
            sreg     <= Out_Gray;
            bit_cnt  <= LAST_BIT;
            hold_cnt <= HOLD_MAX;
            Out_Busy <= 1'b1;
            Out_Sbit <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (In_Send) Out_Overrun <= 1'b1;
          if (hold_cnt == '0) begin
            if (bit_cnt == '0) begin
              sreg     <= '0;
              Out_Busy <= 1'b0;
              Out_Done <= 1'b1;
              state    <= IDLE;
            end else begin
              sreg     <= {sreg[WIDTH-2:0], 1'b0};
              bit_cnt  <= bit_cnt - BW'(1);
              hold_cnt <= HOLD_MAX;
              Out_Sbit <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_bcid_tx.sv
// Directed bench for gray_bcid_tx: counter/Gray table, wrap and clear corners, serializer timing, overrun, reset abort.
module tb_gray_bcid_tx;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        In_Run = 1'b0, In_Tick = 1'b0, In_Clear = 1'b0, In_Send = 1'b0;
  logic [11:0] Out_Bin, Out_Gray;
  logic        Out_Wrap, Out_Sdata, Out_Sbit, Out_Busy, Out_Done, Out_Overrun;

  int n_cmp = 0;
  int n_bad = 0;

  gray_bcid_tx #(.WIDTH(12), .BIT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .In_Run(In_Run), .In_Tick(In_Tick), .In_Clear(In_Clear),
    .In_Send(In_Send), .Out_Bin(Out_Bin), .Out_Gray(Out_Gray), .Out_Wrap(Out_Wrap),
    .Out_Sdata(Out_Sdata), .Out_Sbit(Out_Sbit), .Out_Busy(Out_Busy), .Out_Done(Out_Done),
    .Out_Overrun(Out_Overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        run, tick, clear;
    logic [11:0] bin, gray;
    logic        wrap;
  } vec_t;

  vec_t        tbl [25];
  logic [11:0] g16 [16];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " bin"}, Out_Bin, 0);
    chk({nm, " gray"}, Out_Gray, 0);
    chk({nm, " flags"}, {Out_Wrap, Out_Sdata, Out_Sbit, Out_Busy, Out_Done, Out_Overrun}, 0);
  endtask

  // Caller drives In_Send=1 before the start edge; checks {busy,sbit,sdata,done,overrun} every cycle.
  task automatic shift_check(input string nm, input logic [11:0] word, input int extra, input bit chain);
    logic exp_sd;
    for (int c = 0; c <= 48; c++) begin
      step();
      exp_sd = (c < 48) ? word[11 - c / 4] : 1'b0;
      chk($sformatf("%s c%0d", nm, c),
          {Out_Busy, Out_Sbit, Out_Sdata, Out_Done, Out_Overrun},
          {(c < 48), (c < 48 && c % 4 == 0), exp_sd, (c == 48), (extra > 0 && c == extra)});
      In_Send = (c + 1 == extra) || (chain && c == 48);
    end
  endtask

  initial begin
    g16 = '{12'h000, 12'h001, 12'h003, 12'h002, 12'h006, 12'h007, 12'h005, 12'h004,
            12'h00C, 12'h00D, 12'h00F, 12'h00E, 12'h00A, 12'h00B, 12'h009, 12'h008};
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 12'(i + 1), g16[i], 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 12'd16, 12'h018, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 12'd0,  12'h018, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 12'd1,  12'h000, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 12'd2,  12'h001, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 12'd3,  12'h003, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 12'd4,  12'h002, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 12'd5,  12'h006, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 1'b1, 12'd0,  12'h007, 1'b0};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 12'd0,  12'h000, 1'b0};

    // Reset held while other inputs are active must still win.
    Rst = 1'b1; In_Run = 1'b1; In_Tick = 1'b1; In_Send = 1'b1;
    step(); step();
    chk_all_zero("reset");
    Rst = 1'b0; In_Tick = 1'b0; In_Send = 1'b0;

    for (int i = 0; i < 25; i++) begin
      In_Run = tbl[i].run; In_Tick = tbl[i].tick; In_Clear = tbl[i].clear;
      step();
      chk($sformatf("vec%0d bin", i), Out_Bin, tbl[i].bin);
      chk($sformatf("vec%0d gray", i), Out_Gray, tbl[i].gray);
      chk($sformatf("vec%0d wrap", i), Out_Wrap, tbl[i].wrap);
    end
    In_Run = 1'b1; In_Tick = 1'b0; In_Clear = 1'b0;

    // Roll over from 0xFFF.
    In_Tick = 1'b1;
    repeat (4095) step();
    In_Tick = 1'b0;
    step();
    chk("top bin", Out_Bin, 12'hFFF);
    chk("top gray", Out_Gray, 12'h800);
    chk("top wrap", Out_Wrap, 0);
    In_Tick = 1'b1;
    step();
    In_Tick = 1'b0;
    chk("wrap bin", Out_Bin, 0);
    chk("wrap pulse", Out_Wrap, 1);
    chk("wrap gray lag", Out_Gray, 12'h800);
    step();
    chk("wrap end", Out_Wrap, 0);
    chk("wrap gray", Out_Gray, 12'h000);

    // Counter to 10 -> Gray 0x00F, then serialize.
    In_Clear = 1'b1; step(); In_Clear = 1'b0;
    In_Tick = 1'b1; repeat (10) step(); In_Tick = 1'b0;
    step();
    chk("pre-send gray", Out_Gray, 12'h00F);
    In_Send = 1'b1;
    shift_check("plain", 12'h00F, 0, 1'b0);
    chk("idle sdata", {Out_Sdata, Out_Busy}, 0);
    step();
    chk("idle after done", {Out_Sdata, Out_Busy, Out_Done}, 0);

    In_Send = 1'b1;
    shift_check("overrun", 12'h00F, 10, 1'b1);
    shift_check("chained", 12'h00F, 0, 1'b0);

    // Ticks keep running during the shift; serial word is the captured one.
    In_Tick = 1'b1; In_Send = 1'b1;
    shift_check("ticking", 12'h00F, 0, 1'b0);
    In_Tick = 1'b0;
    chk("ticking bin", Out_Bin, 12'h03B);
    chk("ticking gray", Out_Gray, 12'h027);

    // Reset 20 cycles into a shift.
    In_Send = 1'b1;
    step();
    In_Send = 1'b0;
    repeat (19) step();
    chk("mid-shift busy", Out_Busy, 1);
    Rst = 1'b1;
    step();
    chk_all_zero("abort");
    Rst = 1'b0; In_Send = 1'b1;
    shift_check("post-reset", 12'h000, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
